// File: rtl/md_issue.sv
// HI/LO issue control: tracks the multiply/divide instruction in E, starts the unit,
// shadows its busy window and stalls D-stage HI/LO instructions while it is occupied.
module md_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_md_op,
    input  logic        stall_other,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        md_busy,
    output logic        md_stall,
    output logic        Start,
    output logic [2:0]  MDOp,
    output logic        MDWrite,
    output logic        MDsel,
    output logic [31:0] MD1,
    output logic [31:0] MD2,
    output logic [3:0]  e_md_op,
    output logic        mirror_busy,
    output logic        sync_err,
    output logic [15:0] stall_cnt
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    logic [3:0]  e_md_op_reg;
    logic [3:0]  e_md_op_next;
    logic [3:0]  shadow_cnt_reg;
    logic [3:0]  shadow_cnt_next;
    logic        sync_err_reg;
    logic        sync_err_next;
    logic [15:0] stall_cnt_reg;
    logic [15:0] stall_cnt_next;

    logic        d_is_md;
    logic        e_is_mult;
    logic        e_is_div;
    logic        start_int;
    logic        stall_int;
    logic        mirror_int;

    assign d_is_md    = (d_md_op >= OP_MULT) && (d_md_op <= OP_MTLO);
    assign e_is_mult  = (e_md_op_reg == OP_MULT) || (e_md_op_reg == OP_MULTU);
    assign e_is_div   = (e_md_op_reg == OP_DIV)  || (e_md_op_reg == OP_DIVU);
    assign start_int  = e_is_mult || e_is_div;
    assign mirror_int = (shadow_cnt_reg != 4'd0);
    assign stall_int  = d_is_md && (start_int || md_busy || mirror_int);

    // Operator decode for the E-stage instruction.
    always_comb begin
        MDOp    = 3'd7;
        MDWrite = 1'b0;
        MDsel   = 1'b0;
        case (e_md_op_reg)
            OP_MULT:  MDOp = 3'd0;
            OP_MULTU: MDOp = 3'd1;
            OP_DIV:   MDOp = 3'd2;
            OP_DIVU:  MDOp = 3'd3;
            OP_MFHI:  MDsel = 1'b1;
            OP_MTHI:  begin MDOp = 3'd4; MDWrite = 1'b1; end
            OP_MTLO:  begin MDOp = 3'd5; MDWrite = 1'b1; end
            default:  MDOp = 3'd7;
        endcase
    end

    // Either stall source turns the instruction entering E into a bubble;
    // out-of-range codes are folded to NONE so downstream decode never sees them.
    always_comb begin
        e_md_op_next = d_is_md ? d_md_op : OP_NONE;
        if (stall_int || stall_other) begin
            e_md_op_next = OP_NONE;
        end
    end

    // A start always reloads, even if a window is still open; that case is flagged below.
    always_comb begin
        shadow_cnt_next = shadow_cnt_reg;
        if (start_int) begin
            shadow_cnt_next = e_is_mult ? MULT_CYCLES : DIV_CYCLES;
        end else if (shadow_cnt_reg != 4'd0) begin
            shadow_cnt_next = shadow_cnt_reg - 4'd1;
        end
    end

    always_comb begin
        sync_err_next = sync_err_reg;
        if ((mirror_int != md_busy) || (start_int && mirror_int)) begin
            sync_err_next = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_int && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_md_op_reg    <= OP_NONE;
            shadow_cnt_reg <= 4'd0;
            sync_err_reg   <= 1'b0;
            stall_cnt_reg  <= 16'd0;
        end else begin
            e_md_op_reg    <= e_md_op_next;
            shadow_cnt_reg <= shadow_cnt_next;
            sync_err_reg   <= sync_err_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    assign md_stall    = stall_int;
    assign Start       = start_int;
    assign MD1         = e_rs;
    assign MD2         = e_rt;
    assign e_md_op     = e_md_op_reg;
    assign mirror_busy = mirror_int;
    assign sync_err    = sync_err_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue: a small behavioural unit drives md_busy back,
// and every expectation below is a hand-computed constant.
module tb_md_issue;

    logic        clk;
    logic        reset;
    logic [3:0]  d_md_op;
    logic        stall_other;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        md_busy;
    logic        md_stall;
    logic        Start;
    logic [2:0]  MDOp;
    logic        MDWrite;
    logic        MDsel;
    logic [31:0] MD1;
    logic [31:0] MD2;
    logic [3:0]  e_md_op;
    logic        mirror_busy;
    logic        sync_err;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    // Unit stand-in: busy for 5 cycles after a multiply start, 10 after a divide start.
    logic [3:0] unit_cnt;
    logic       force_low;

    md_issue dut (
        .clk(clk), .reset(reset), .d_md_op(d_md_op), .stall_other(stall_other),
        .e_rs(e_rs), .e_rt(e_rt), .md_busy(md_busy), .md_stall(md_stall),
        .Start(Start), .MDOp(MDOp), .MDWrite(MDWrite), .MDsel(MDsel),
        .MD1(MD1), .MD2(MD2), .e_md_op(e_md_op), .mirror_busy(mirror_busy),
        .sync_err(sync_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            unit_cnt <= 4'd0;
        end else if (Start) begin
            unit_cnt <= (MDOp <= 3'd1) ? 4'd5 : 4'd10;
        end else if (unit_cnt != 4'd0) begin
            unit_cnt <= unit_cnt - 4'd1;
        end
    end

    assign md_busy = (unit_cnt != 4'd0) && !force_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        force_low   = 1'b0;
        reset       = 1'b1;
        d_md_op     = 4'd0;
        stall_other = 1'b0;
        e_rs        = 32'd0;
        e_rt        = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_start",   {31'd0, Start},       32'd0);
        check("rst_mdwrite", {31'd0, MDWrite},     32'd0);
        check("rst_mdsel",   {31'd0, MDsel},       32'd0);
        check("rst_mdop",    {29'd0, MDOp},        32'd7);
        check("rst_stall",   {31'd0, md_stall},    32'd0);
        check("rst_mirror",  {31'd0, mirror_busy}, 32'd0);
        check("rst_e_op",    {28'd0, e_md_op},     32'd0);
        check("rst_syncerr", {31'd0, sync_err},    32'd0);
        check("rst_stallcnt",{16'd0, stall_cnt},   32'd0);

        // MULT enters E with rs=3, rt=5
        d_md_op = 4'd1;
        e_rs = 32'd3;
        e_rt = 32'd5;
        tick();
        d_md_op = 4'd0;
        #1;
        check("mult_start", {31'd0, Start}, 32'd1);
        check("mult_mdop",  {29'd0, MDOp},  32'd0);
        check("mult_md1",   MD1,            32'd3);
        check("mult_md2",   MD2,            32'd5);
        check("none_nostall", {31'd0, md_stall}, 32'd0);
        tick();
        check("mult_once", {31'd0, Start}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (mirror_busy) n++;
            tick();
        end
        check("mult_busy_len", n, 32'd5);
        check("mult_sync_ok", {31'd0, sync_err}, 32'd0);

        // DIV followed directly by MFLO
        d_md_op = 4'd3;
        tick();
        d_md_op = 4'd6;
        #1;
        n = 0;
        while (md_stall && n < 40) begin
            n++;
            tick();
        end
        check("div_stall_len", n, 32'd11);
        check("div_stall_cnt", {16'd0, stall_cnt}, 32'd11);
        tick();
        d_md_op = 4'd0;
        #1;
        check("mflo_in_e",   {28'd0, e_md_op}, 32'd6);
        check("mflo_mdsel",  {31'd0, MDsel},   32'd0);
        check("mflo_mdop",   {29'd0, MDOp},    32'd7);

        // MFHI selects HI
        d_md_op = 4'd5;
        tick();
        d_md_op = 4'd0;
        #1;
        check("mfhi_mdsel", {31'd0, MDsel}, 32'd1);

        // MTHI / MTLO direct writes
        e_rs = 32'hDEAD_BEEF;
        d_md_op = 4'd7;
        tick();
        d_md_op = 4'd8;
        #1;
        check("mthi_mdwrite", {31'd0, MDWrite}, 32'd1);
        check("mthi_mdop",    {29'd0, MDOp},    32'd4);
        check("mthi_start",   {31'd0, Start},   32'd0);
        check("mthi_md1",     MD1,              32'hDEAD_BEEF);
        tick();
        d_md_op = 4'd0;
        #1;
        check("mtlo_mdop",    {29'd0, MDOp},    32'd5);
        check("mtlo_mdwrite", {31'd0, MDWrite}, 32'd1);

        // Out-of-range code folds to NONE
        d_md_op = 4'd12;
        #1;
        check("bad_nostall", {31'd0, md_stall}, 32'd0);
        tick();
        d_md_op = 4'd0;
        #1;
        check("bad_as_none", {28'd0, e_md_op}, 32'd0);

        // stall_other bubbles a MULT
        d_md_op = 4'd1;
        stall_other = 1'b1;
        tick();
        stall_other = 1'b0;
        d_md_op = 4'd0;
        #1;
        check("so_e_op",  {28'd0, e_md_op}, 32'd0);
        check("so_start", {31'd0, Start},   32'd0);
        tick();
        check("so_noload", {31'd0, mirror_busy}, 32'd0);

        // Reset in the middle of a DIV window (counter = 6)
        d_md_op = 4'd3;
        tick();
        d_md_op = 4'd0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("div_mid_busy", {31'd0, mirror_busy}, 32'd1);
        check("div_mid_cnt",  {16'd0, stall_cnt},   32'd11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_mirror",   {31'd0, mirror_busy}, 32'd0);
        check("abort_e_op",     {28'd0, e_md_op},     32'd0);
        check("abort_stallcnt", {16'd0, stall_cnt},   32'd0);

        // md_busy held low while the shadow counts
        force_low = 1'b1;
        d_md_op = 4'd2;
        tick();
        d_md_op = 4'd0;
        tick();
        check("se_before", {31'd0, sync_err}, 32'd0);
        tick();
        check("se_set", {31'd0, sync_err}, 32'd1);
        force_low = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("se_sticky", {31'd0, sync_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("se_cleared", {31'd0, sync_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-003 SHALL have port d_md_op, input, 4, D-stage HI/LO class: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-004 SHALL have port stall_other, input, 1, stall demanded by other hazard logic.
REQ-005 SHALL have port e_rs, input, 32, forwarded rs value in E.
REQ-006 SHALL have port e_rt, input, 32, forwarded rt value in E.
REQ-007 SHALL have port md_busy, input, 1, Busy returned by the multiply/divide unit.
REQ-008 SHALL have port md_stall, output, 1, freeze F/D and bubble E for an HI/LO instruction.
REQ-009 SHALL have port Start, output, 1, start pulse to the multiply/divide unit.
REQ-010 SHALL have port MDOp, output, 3, unit opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 7 idle.
REQ-011 SHALL have port MDWrite, output, 1, HI/LO direct-write enable.
REQ-012 SHALL have port MDsel, output, 1, read select: 0 LO, 1 HI.
REQ-013 SHALL have port MD1, output, 32, first operand.
REQ-014 SHALL have port MD2, output, 32, second operand.
REQ-015 SHALL have port e_md_op, output, 4, registered E-stage class, same encoding as d_md_op.
REQ-016 SHALL have port mirror_busy, output, 1, internal shadow of the unit's busy window.
REQ-017 SHALL have port sync_err, output, 1, sticky: shadow disagreed with md_busy.
REQ-018 SHALL have port stall_cnt, output, 16, saturating count of cycles with md_stall high.

Function
REQ-019 SHALL register e_md_op <= NONE when md_stall or stall_other is high, else d_md_op (codes 9-15 stored as NONE).
REQ-020 SHALL drive Start = 1 combinationally when e_md_op is MULT, MULTU, DIV or DIVU; exactly one pulse per instruction.
REQ-021 SHALL drive MDWrite = 1 when e_md_op is MTHI or MTLO; never together with Start.
REQ-022 SHALL drive MDsel = 1 only when e_md_op is MFHI, else 0.
REQ-023 SHALL map e_md_op to MDOp per REQ-010; MFHI, MFLO, NONE give MDOp = 7.
REQ-024 SHALL pass MD1 = e_rs and MD2 = e_rt unmodified, every cycle.
REQ-025 SHALL keep a 4-bit shadow counter: load 5 on a MULT/MULTU Start edge, 10 on DIV/DIVU Start edge, else decrement while nonzero, hold at 0.
REQ-026 SHALL drive mirror_busy = (shadow counter != 0).
REQ-027 SHALL drive md_stall = (d_md_op in 1..8) and (Start or md_busy or mirror_busy).
REQ-028 SHALL not stall a D-stage NONE instruction, whatever the busy state.
REQ-029 SHALL set sync_err on any rising edge where mirror_busy != md_busy; only reset clears it.
REQ-030 SHALL increment stall_cnt each cycle md_stall is high, saturating at 16'hFFFF.
REQ-031 SHALL, on a Start edge while the shadow counter is nonzero (illegal), reload per REQ-025 and set sync_err.
REQ-032 SHALL give stall priority to both md_stall and stall_other equally: either one inserts a bubble.

Reset
REQ-033 SHALL on reset clear e_md_op to NONE, shadow counter to 0, sync_err to 0, stall_cnt to 0.
REQ-034 SHALL after reset show Start=0, MDWrite=0, MDsel=0, MDOp=7, md_stall=0, mirror_busy=0.
REQ-035 SHALL abort a busy window when reset is asserted mid-operation; mirror_busy is 0 the cycle after.

Verification
REQ-036 SHALL cover: MULT into E with e_rs=3, e_rt=5 -> Start=1, MDOp=0, MD1=3, MD2=5; mirror_busy high exactly 5 cycles.
REQ-037 SHALL cover: DIV then MFLO directly behind -> md_stall high 11 cycles (Start cycle + 10), stall_cnt=11, MFLO enters E with MDsel=0.
REQ-038 SHALL cover: MTHI in E with e_rs=32'hDEAD_BEEF -> MDWrite=1, MDOp=4, Start=0.
REQ-039 SHALL cover: md_busy held low while shadow counts -> sync_err=1 next edge, stays 1 until reset.
REQ-040 SHALL cover: reset during DIV busy window (counter=6) -> next cycle mirror_busy=0, e_md_op=NONE, stall_cnt=0.
REQ-041 SHALL cover: stall_other=1 with d_md_op=MULT -> e_md_op=NONE next cycle, Start=0, no counter load.
